// File: rtl/pim_shift_accum.sv
// Bit-serial PIM result reconstruction: accumulates per-bit-plane ADC counts, LSB plane first,
// into a shifted dot-product sum. It then holds the result on a valid/ready handshake.

package pim_shift_accum_pkg;
   function automatic int clogb2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction
endpackage

module pim_shift_accum
   import pim_shift_accum_pkg::*;
#(
   parameter  int ADC_P   = 4,
   parameter  int INPUT_P = 4,
   parameter  int SIGNED  = 0,
   localparam int OUT_W   = ADC_P + INPUT_P,
   localparam int CW      = clogb2(INPUT_P)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             adc_valid,
   input  logic [ADC_P-1:0] adc_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] sum,
   output logic             busy,
   output logic [CW-1:0]    plane_idx,
   output logic             overrun
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t           state;
   logic [OUT_W-1:0] acc;
   logic [OUT_W-1:0] data_ext;
   logic [OUT_W-1:0] term;
   logic [OUT_W-1:0] next_acc;
   logic             last_plane;

   // In two's-complement mode the MSB plane carries negative weight.
   always_comb begin
      data_ext   = {{INPUT_P{1'b0}}, adc_data};
      term       = data_ext << plane_idx;
      last_plane = (plane_idx == CW'(INPUT_P - 1));
      if ((SIGNED != 0) && last_plane)
         next_acc = acc - term;
      else
         next_acc = acc + term;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         sum       <= '0;
         plane_idx <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (adc_valid)
                  overrun <= 1'b1;
               if (start) begin
                  state     <= ACCUM;
                  acc       <= '0;
                  plane_idx <= '0;
                  busy      <= 1'b1;
               end
            end
            ACCUM: begin
               // A restart wins over a same-cycle sample.
               if (start) begin
                  acc       <= '0;
                  plane_idx <= '0;
               end else if (adc_valid) begin
                  acc <= next_acc;
                  if (last_plane) begin
                     state     <= HOLD;
                     sum       <= next_acc;
                     out_valid <= 1'b1;
                     busy      <= 1'b0;
                     plane_idx <= '0;
                  end else begin
                     plane_idx <= plane_idx + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (adc_valid)
                  overrun <= 1'b1;
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (start) begin
                     state     <= ACCUM;
                     acc       <= '0;
                     plane_idx <= '0;
                     busy      <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
